// File: rtl/game_pkg.sv
// Shared state codes, decision encoding and state classification helpers for
// the Game adventure FSM and its automated player.
package game_pkg;

    localparam logic [4:0] ST_HUB        = 5'd1;
    localparam logic [4:0] ST_BEDROOM    = 5'd2;
    localparam logic [4:0] ST_BATH       = 5'd3;
    localparam logic [4:0] ST_KITCHEN    = 5'd4;
    localparam logic [4:0] ST_OUTSIDE    = 5'd5;
    localparam logic [4:0] ST_CAMPUS     = 5'd6;
    localparam logic [4:0] ST_NAP        = 5'd7;
    localparam logic [4:0] ST_MASK       = 5'd8;
    localparam logic [4:0] ST_WIN        = 5'd9;
    localparam logic [4:0] ST_LOSE_SICK  = 5'd10;
    localparam logic [4:0] ST_SOCIAL     = 5'd11;
    localparam logic [4:0] ST_STUDY      = 5'd12;
    localparam logic [4:0] ST_LOSE_PARTY = 5'd13;
    localparam logic [4:0] ST_FRIENDS    = 5'd14;
    localparam logic [4:0] ST_HALLWAY    = 5'd15;
    localparam logic [4:0] ST_LIBRARY    = 5'd16;
    localparam logic [4:0] ST_LECTURE    = 5'd17;
    localparam logic [4:0] ST_VIDEOS     = 5'd18;
    localparam logic [4:0] ST_CAFE       = 5'd19;
    localparam logic [4:0] ST_WANDER     = 5'd20;
    localparam logic [4:0] ST_IDLE       = 5'd21;

    typedef enum logic [1:0] {
        DEC_A = 2'd0,
        DEC_B = 2'd1,
        DEC_C = 2'd2,
        DEC_D = 2'd3
    } decision_t;

    // One flag per motivation source; each pays out only on its first visit.
    typedef struct packed {
        logic bath;
        logic kitchen;
        logic outside;
        logic nap;
        logic friends;
        logic lecture;
        logic videos;
    } used_t;

    function automatic logic is_menu(input logic [4:0] state);
        case (state)
            ST_HUB, ST_BEDROOM, ST_CAMPUS, ST_SOCIAL, ST_STUDY: return 1'b1;
            default:                                            return 1'b0;
        endcase
    endfunction

    function automatic used_t source_bit(input logic [4:0] state);
        used_t s;
        s = '0;
        case (state)
            ST_BATH:     s.bath    = 1'b1;
            ST_KITCHEN:  s.kitchen = 1'b1;
            ST_OUTSIDE:  s.outside = 1'b1;
            ST_NAP:      s.nap     = 1'b1;
            ST_FRIENDS:  s.friends = 1'b1;
            ST_LECTURE:  s.lecture = 1'b1;
            ST_VIDEOS:   s.videos  = 1'b1;
            default:     s         = '0;
        endcase
        return s;
    endfunction

    function automatic logic is_source(input logic [4:0] state);
        return source_bit(state) != '0;
    endfunction

endpackage

// File: rtl/game_policy.sv
// Fixed-priority move selection: gather motivation first, then steer toward
// homework; purely combinational from the current state and consumed sources.
module game_policy
    import game_pkg::*;
(
    input  logic [4:0] state,
    input  logic [6:0] used,
    input  logic       has_mask,
    input  logic       m,
    output logic [1:0] Decision,
    output logic       decision_valid
);

    used_t     u;
    decision_t dec;

    assign u = used_t'(used);

    // NOTE: every output gets a default before the case so no path can infer a latch.
    always_comb begin
        dec            = DEC_A;
        decision_valid = is_menu(state);
        case (state)
            ST_HUB: begin
                if (m)                          dec = DEC_A;
                else if (!u.bath)               dec = DEC_B;
                else if (!u.kitchen)            dec = DEC_C;
                else if (has_mask && !u.outside) dec = DEC_D;
                else                            dec = DEC_A;
            end
            ST_BEDROOM: begin
                if (!has_mask)   dec = DEC_C;
                else if (m)      dec = DEC_A;
                else if (!u.nap) dec = DEC_B;
                else             dec = DEC_A;
            end
            ST_CAMPUS: begin
                if (m)                           dec = DEC_A;
                else if (!u.friends)             dec = DEC_B;
                else if (!u.lecture || !u.videos) dec = DEC_C;
                else                             dec = DEC_D;
            end
            // Choice A here leads straight to a loss, so it is never offered.
            ST_SOCIAL: begin
                dec = u.friends ? DEC_D : DEC_B;
            end
            ST_STUDY: begin
                if (!u.lecture)     dec = DEC_A;
                else if (!u.videos) dec = DEC_B;
                else                dec = DEC_D;
            end
            default: dec = DEC_A;
        endcase
    end

    assign Decision = dec;

endmodule

// File: rtl/game_autoplayer.sv
// Automated player for Game: tracks consumed motivation sources, counts moves,
// detects win/loss/timeout and drives a zero-latency Decision every cycle.
module game_autoplayer
    import game_pkg::*;
#(
    parameter int MOTIV_NEED = 5,
    parameter int MAX_MOVES  = 31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] state,
    output logic [1:0] Decision,
    output logic       decision_valid,
    output logic [2:0] motivation,
    output logic [4:0] move_count,
    output logic       done,
    output logic       success,
    output logic       timeout
);

    localparam logic [2:0] NEED_Q  = 3'(MOTIV_NEED);
    localparam logic [5:0] LIMIT_Q = 6'(MAX_MOVES);

    logic [4:0] state_q;
    used_t      used;
    logic       has_mask;

    logic       entry;
    used_t      src;
    logic       fresh_source;
    logic       enter_win;
    logic       enter_lose;
    logic [5:0] count_next;
    logic       m;
    logic [1:0] pol_decision;
    logic       pol_valid;

    // state_q resets to 0, an invalid code, so the first real state is an entry.
    assign entry        = (state != state_q) && !done;
    assign src          = source_bit(state);
    assign fresh_source = entry && is_source(state) && ((src & ~used) != '0);
    assign enter_win    = entry && (state == ST_WIN);
    assign enter_lose   = entry && ((state == ST_LOSE_SICK) || (state == ST_LOSE_PARTY));
    assign count_next   = {1'b0, move_count} + 6'd1;
    assign m            = (motivation >= NEED_Q);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= '0;
            used       <= '0;
            has_mask   <= 1'b0;
            motivation <= '0;
            move_count <= '0;
            done       <= 1'b0;
            success    <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q <= state;

            if (entry) begin
                used <= used | src;
                if (state == ST_MASK)
                    has_mask <= 1'b1;
            end

            if (fresh_source && (motivation != 3'd7))
                motivation <= motivation + 3'd1;

            if (!done) begin
                if ({1'b0, move_count} != LIMIT_Q)
                    move_count <= count_next[4:0];

                // A terminal entry outranks a timeout landing on the same edge.
                if (enter_win) begin
                    done    <= 1'b1;
                    success <= 1'b1;
                end else if (enter_lose) begin
                    done    <= 1'b1;
                end else if (count_next == LIMIT_Q) begin
                    done    <= 1'b1;
                    timeout <= 1'b1;
                end
            end
        end
    end

    game_policy u_policy (
        .state          (state),
        .used           (used),
        .has_mask       (has_mask),
        .m              (m),
        .Decision       (pol_decision),
        .decision_valid (pol_valid)
    );

    assign Decision       = done ? 2'd0 : pol_decision;
    assign decision_valid = pol_valid && !done;

endmodule
